// File: rtl/addsub_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor: opcodes, FSM states and
// the counter-width helper.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    // Bits needed to count n chunks; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder slice with carry in and carry out.
module addsub_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] x_i,
    input  logic [CHUNK-1:0] y_i,
    input  logic             ci_i,
    output logic [CHUNK-1:0] s_o,
    output logic             co_o
);

    assign {co_o, s_o} = {1'b0, x_i} + {1'b0, y_i} + {{CHUNK{1'b0}}, ci_i};

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor: CHUNK bits per clock, LSB chunk first,
// with start/ready/done handshake and carry, overflow and zero flags.
module addsub_seq
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] out_o,
    output logic             co_o,
    output logic             of_o,
    output logic             zf_o
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned CntW = cnt_width(N);
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : gen_bad_params
        $error("addsub_seq: CHUNK must divide WIDTH and lie in 1..WIDTH");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d, res_q, res_d, out_q, out_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d, msba_q, msba_d, msbb_q, msbb_d;
    logic              co_q, co_d, of_q, of_d, zf_q, zf_d, done_q, done_d;

    logic [CHUNK-1:0]  sum;
    logic              sum_co;
    logic [WIDTH-1:0]  res_shift;

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x_i  (opa_q[CHUNK-1:0]),
        .y_i  (opb_q[CHUNK-1:0]),
        .ci_i (carry_q),
        .s_o  (sum),
        .co_o (sum_co)
    );

    // New chunk enters at the MSB end so the result is aligned after N shifts.
    if (CHUNK == WIDTH) begin : gen_single
        assign res_shift = sum;
    end else begin : gen_multi
        assign res_shift = {sum, res_q[WIDTH-1:CHUNK]};
    end

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        msba_d  = msba_q;
        msbb_d  = msbb_q;
        out_d   = out_q;
        co_d    = co_q;
        of_d    = of_q;
        zf_d    = zf_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    opa_d   = a_i;
                    opb_d   = (op_i == OP_SUB) ? ~b_i : b_i;
                    carry_d = op_i;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d   = res_shift;
                opa_d   = opa_q >> CHUNK;
                opb_d   = opb_q >> CHUNK;
                carry_d = sum_co;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    // Operand sign bits sit at the top of the final chunk.
                    msba_d  = opa_q[CHUNK-1];
                    msbb_d  = opb_q[CHUNK-1];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_d   = res_q;
                co_d    = carry_q;
                of_d    = (msba_q == msbb_q) && (res_q[WIDTH-1] != msba_q);
                zf_d    = (res_q == '0);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            msba_q  <= 1'b0;
            msbb_q  <= 1'b0;
            out_q   <= '0;
            co_q    <= 1'b0;
            of_q    <= 1'b0;
            zf_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            msba_q  <= msba_d;
            msbb_q  <= msbb_d;
            out_q   <= out_d;
            co_q    <= co_d;
            of_q    <= of_d;
            zf_q    <= zf_d;
            done_q  <= done_d;
        end
    end

    assign ready_o = (state_q == S_IDLE);
    assign done_o  = done_q;
    assign out_o   = out_q;
    assign co_o    = co_q;
    assign of_o    = of_q;
    assign zf_o    = zf_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Scoreboard bench for addsub_seq: a WIDTH=32/CHUNK=8 instance plus a CHUNK=32 instance.
module tb_addsub_seq;

    logic        clk;
    logic        rstn;
    logic        start, start1;
    logic        op;
    logic [31:0] a, b;
    logic        ready, done, co, of, zf;
    logic [31:0] out;
    logic        ready1, done1, co1, of1, zf1;
    logic [31:0] out1;

    int nvec  = 0;
    int nfail = 0;
    logic [34:0] sb[$];

    addsub_seq #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk_i(clk), .rst_ni(rstn), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
        .ready_o(ready), .done_o(done), .out_o(out), .co_o(co), .of_o(of), .zf_o(zf)
    );

    addsub_seq #(.WIDTH(32), .CHUNK(32)) u_dut1 (
        .clk_i(clk), .rst_ni(rstn), .start_i(start1), .op_i(op), .a_i(a), .b_i(b),
        .ready_o(ready1), .done_o(done1), .out_o(out1), .co_o(co1), .of_o(of1), .zf_o(zf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: {out, co, of, zf}
    function automatic logic [34:0] model(input logic o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic        c, v;
        if (o) begin
            r = x - y;
            c = (x >= y);
            v = (x[31] != y[31]) && (r[31] != x[31]);
        end else begin
            r = x + y;
            c = ({1'b0, x} + {1'b0, y}) > 33'h0_FFFF_FFFF;
            v = (x[31] == y[31]) && (r[31] != x[31]);
        end
        return {r, c, v, (r == 32'd0)};
    endfunction

    // Drives a one-cycle start on the 8-bit-chunk DUT and records the expectation.
    task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y,
                         input logic [34:0] exp);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges until done is seen at a negedge; lat = -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic collect(output int lat, output logic [34:0] got, output logic [34:0] exp);
        wait_done(lat);
        got = {out, co, of, zf};
        exp = (sb.size() > 0) ? sb.pop_front() : {35{1'bx}};
    endtask

    task automatic test_reset;
        rstn = 1'b0; start = 1'b0; start1 = 1'b0; op = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        nvec++;
        if ({ready, done, out, co, of, zf} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
            nfail++;
            $display("FAIL reset_state: got rdy=%b done=%b out=%h flags=%b%b%b want 1 0 0 000",
                     ready, done, out, co, of, zf);
        end
        rstn = 1'b1;
    endtask

    task automatic test_vectors;
        logic [34:0] got, exp;
        int lat;
        logic [32:0] ops[8] = '{{1'b0, 32'h0000_0005}, {1'b0, 32'h0000_00FF},
                                {1'b0, 32'hFFFF_FFFF}, {1'b1, 32'h0000_0005},
                                {1'b1, 32'h0000_0003}, {1'b0, 32'h7FFF_FFFF},
                                {1'b1, 32'h8000_0000}, {1'b0, 32'h0000_0002}};
        logic [31:0] bs[8]  = '{32'd3, 32'd1, 32'd1, 32'd5, 32'd5, 32'd1, 32'd1, 32'd2};
        logic [34:0] exps[8] = '{{32'h0000_0008, 3'b000}, {32'h0000_0100, 3'b000},
                                 {32'h0000_0000, 3'b101}, {32'h0000_0000, 3'b101},
                                 {32'hFFFF_FFFE, 3'b000}, {32'h8000_0000, 3'b010},
                                 {32'h7FFF_FFFF, 3'b110}, {32'h0000_0004, 3'b000}};
        for (int i = 0; i < 8; i++) begin
            issue(ops[i][32], ops[i][31:0], bs[i], exps[i]);
            nvec++;
            if (ready !== 1'b0) begin
                nfail++;
                $display("FAIL vec%0d_ready_drop: got %b want 0", i, ready);
            end
            collect(lat, got, exp);
            nvec++;
            if (lat != 5) begin
                nfail++;
                $display("FAIL vec%0d_latency: got %0d want 5", i, lat);
            end
            nvec++;
            if (got !== exp) begin
                nfail++;
                $display("FAIL vec%0d_result: got %h want %h", i, got, exp);
            end
            @(negedge clk);
            nvec++;
            if (done !== 1'b0) begin
                nfail++;
                $display("FAIL vec%0d_done_pulse: got %b want 0", i, done);
            end
        end
    endtask

    task automatic test_random;
        logic [34:0] got, exp;
        logic [31:0] x, y;
        logic o;
        int lat;
        for (int i = 0; i < 10; i++) begin
            x = $urandom; y = $urandom; o = 1'($urandom_range(1));
            if (i < 2) y = x;
            issue(o, x, y, model(o, x, y));
            collect(lat, got, exp);
            nvec++;
            if (lat != 5 || got !== exp) begin
                nfail++;
                $display("FAIL rand%0d op=%b a=%h b=%h: got %h lat %0d want %h lat 5",
                         i, o, x, y, got, lat, exp);
            end
        end
    endtask

    task automatic test_start_ignored;
        logic [34:0] got, exp;
        int lat, pulses;
        issue(1'b1, 32'd10, 32'd4, {32'd6, 3'b100});
        @(negedge clk);
        op = 1'b0; a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        lat = (lat < 0) ? lat : lat + 2;
        got = {out, co, of, zf};
        exp = (sb.size() > 0) ? sb.pop_front() : {35{1'bx}};
        nvec++;
        if (lat != 5 || got !== exp) begin
            nfail++;
            $display("FAIL ignore_start: got %h lat %0d want %h lat 5", got, lat, exp);
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        nvec++;
        if (pulses != 0) begin
            nfail++;
            $display("FAIL ignore_extra_done: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_back_to_back;
        logic [34:0] got, exp;
        int lat;
        @(negedge clk);
        op = 1'b0; a = 32'd1; b = 32'd2; start = 1'b1;
        sb.push_back({32'd3, 3'b000});
        sb.push_back({32'd3, 3'b000});
        @(posedge clk);
        @(negedge clk);
        collect(lat, got, exp);
        nvec++;
        if (lat != 5 || got !== exp) begin
            nfail++;
            $display("FAIL b2b_first: got %h lat %0d want %h lat 5", got, lat, exp);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        nvec++;
        if (ready !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_reaccept: ready got %b want 0", ready);
        end
        collect(lat, got, exp);
        nvec++;
        if (lat != 5 || got !== exp) begin
            nfail++;
            $display("FAIL b2b_second: got %h lat %0d want %h lat 5", got, lat, exp);
        end
    endtask

    task automatic test_abort;
        logic [34:0] got, exp;
        int lat, pulses;
        issue(1'b0, 32'h1234_5678, 32'h1111_1111, model(1'b0, 32'h1234_5678, 32'h1111_1111));
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        sb.delete();
        #1;
        nvec++;
        if ({ready, done, out, co, of, zf} !== {1'b1, 1'b0, 32'd0, 3'b000}) begin
            nfail++;
            $display("FAIL abort_clear: got rdy=%b done=%b out=%h flags=%b%b%b want 1 0 0 000",
                     ready, done, out, co, of, zf);
        end
        @(negedge clk);
        rstn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        nvec++;
        if (pulses != 0) begin
            nfail++;
            $display("FAIL abort_no_done: got %0d pulses want 0", pulses);
        end
        issue(1'b0, 32'd2, 32'd2, {32'd4, 3'b000});
        collect(lat, got, exp);
        nvec++;
        if (lat != 5 || got !== exp) begin
            nfail++;
            $display("FAIL abort_restart: got %h lat %0d want %h lat 5", got, lat, exp);
        end
    endtask

    task automatic test_single_chunk;
        int lat;
        @(negedge clk);
        op = 1'b0; a = 32'h0000_00FF; b = 32'd1; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done1) begin
                lat = i;
                break;
            end
        end
        nvec++;
        if (lat != 2 || {out1, co1, of1, zf1} !== {32'h0000_0100, 3'b000}) begin
            nfail++;
            $display("FAIL chunk32: got %h flags %b%b%b lat %0d want 00000100 000 lat 2",
                     out1, co1, of1, zf1, lat);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_abort();
        test_single_chunk();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
